// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction memory loader.
//   loader_state_t  - loader FSM states
//   BYTES_PER_WORD  - bytes assembled into one 32-bit instruction word
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    DONE
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_assembler.sv
// word_assembler: collects bytes LSB-first into a 32-bit word and keeps a
// running XOR of every byte it accepts.
//   clk, reset   - clock, async active-high reset
//   clear        - synchronous clear of counter, shift register and XOR
//   shift_en     - accept byte_in this cycle
//   byte_in      - incoming byte
//   word_next    - full word including byte_in (valid when word_ready)
//   acc          - XOR of all bytes accepted since the last clear
//   word_ready   - byte_in completes a word this cycle
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic [7:0]  acc,
  output logic        word_ready
);

  // Only the three earlier bytes need storage; the fourth arrives live on
  // byte_in and is merged in word_next.
  logic [23:0] sreg;
  logic [1:0]  byte_cnt;

  assign word_next  = {byte_in, sreg};
  assign word_ready = shift_en && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg     <= '0;
      byte_cnt <= '0;
      acc      <= '0;
    end else if (clear) begin
      sreg     <= '0;
      byte_cnt <= '0;
      acc      <= '0;
    end else if (shift_en) begin
      sreg     <= word_next[31:8];
      byte_cnt <= byte_cnt + 2'd1;
      acc      <= acc ^ byte_in;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader. Parses a framed byte stream
// (count byte, 4*N data bytes LSB-first, XOR checksum byte) and writes the
// assembled words sequentially into the instruction memory write port.
//   clk, reset          - clock, async active-high reset
//   start               - begin a load (only from IDLE or DONE)
//   rx_valid/rx_data    - byte source
//   rx_ready            - loader accepts a byte (HDR, DATA, CSUM)
//   we/waddr/wdata      - registered instruction memory write port
//   busy                - load in progress
//   done/err            - load finished / load failed (err valid with done)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int alen = 6,
  parameter int ilen = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            rx_valid,
  input  logic [7:0]      rx_data,
  output logic            rx_ready,
  output logic            we,
  output logic [alen-1:0] waddr,
  output logic [ilen-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int DEPTH = 2 ** alen;

  loader_state_t state, state_next;

  // One extra bit so a count of exactly DEPTH is representable.
  logic [alen:0] word_idx;
  logic [alen:0] n_words;

  logic        accept, clear;
  logic        hdr_zero, hdr_big, last_word;
  logic [31:0] word_next;
  logic [7:0]  acc;
  logic        word_ready;

  assign busy     = (state == HDR) || (state == DATA) || (state == CSUM);
  assign rx_ready = busy;
  assign done     = (state == DONE);
  assign accept   = rx_valid && rx_ready;
  assign clear    = start && ((state == IDLE) || (state == DONE));

  assign hdr_zero  = (rx_data == 8'd0);
  assign hdr_big   = (32'(rx_data) > DEPTH);
  assign last_word = (word_idx == n_words - (alen+1)'(1));

  word_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .shift_en   (accept && (state == DATA)),
    .byte_in    (rx_data),
    .word_next  (word_next),
    .acc        (acc),
    .word_ready (word_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = HDR;
      HDR:
        if (accept) begin
          if (hdr_zero || hdr_big) state_next = DONE;
          else                     state_next = DATA;
        end
      DATA: if (word_ready && last_word) state_next = CSUM;
      CSUM: if (accept) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we       <= 1'b0;
      waddr    <= '0;
      wdata    <= '0;
      word_idx <= '0;
      n_words  <= '0;
      err      <= 1'b0;
    end else begin
      we <= 1'b0;
      if (clear) begin
        word_idx <= '0;
        n_words  <= '0;
        err      <= 1'b0;
      end
      if (state == HDR && accept) begin
        n_words <= (alen+1)'(rx_data);
        err     <= hdr_big;
      end
      if (word_ready) begin
        we       <= 1'b1;
        waddr    <= word_idx[alen-1:0];
        wdata    <= ilen'(word_next);
        word_idx <= word_idx + (alen+1)'(1);
      end
      if (state == CSUM && accept) err <= (rx_data != acc);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader. Directed frames from a
// table, reset-abort sequence, and random frames checked against a frame-level
// reference model.
module tb_imem_loader;

  localparam int ALEN  = 6;
  localparam int DEPTH = 2 ** ALEN;

  logic            clk = 0;
  logic            reset = 1;
  logic            start = 0;
  logic            rx_valid = 0;
  logic [7:0]      rx_data = 0;
  logic            rx_ready, we, busy, done, err;
  logic [ALEN-1:0] waddr;
  logic [31:0]     wdata;

  imem_loader #(.alen(ALEN), .ilen(32)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .we(we), .waddr(waddr),
    .wdata(wdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Captured writes.
  int          wa[$];
  logic [31:0] wd[$];
  always @(negedge clk) if (we) begin
    wa.push_back(int'(waddr));
    wd.push_back(wdata);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: interpret a complete frame directly from the format rules.
  logic        exp_err;
  logic [31:0] exp_w[$];
  task automatic model(input logic [7:0] q[$]);
    int n;
    logic [7:0] x;
    exp_w.delete();
    n = int'(q[0]);
    x = 0;
    if (n == 0)          exp_err = 0;
    else if (n > DEPTH)  exp_err = 1;
    else begin
      for (int i = 0; i < n; i++) begin
        exp_w.push_back({q[4*i+4], q[4*i+3], q[4*i+2], q[4*i+1]});
        for (int k = 1; k <= 4; k++) x ^= q[4*i+k];
      end
      exp_err = (q[4*n+1] != x);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
  endtask

  // Offer each byte until accepted; gap is percent chance of an idle cycle.
  task automatic send_bytes(input logic [7:0] q[$], input int gap);
    foreach (q[i]) begin
      int t = 0;
      logic acc_now;
      forever begin
        @(negedge clk);
        if (int'($urandom_range(99)) < gap) begin
          rx_valid = 0; rx_data = 8'($urandom);
        end else begin
          rx_valid = 1; rx_data = q[i];
        end
        #1 acc_now = rx_valid && rx_ready;
        @(posedge clk);
        if (acc_now) break;
        if (++t > 1000) begin
          chk("accept_timeout", 32'(t), 32'd0);
          return;
        end
      end
    end
  endtask

  // Run a frame and check final status plus every write against the model.
  task automatic run_frame(input string tag, input logic [7:0] q[$], input int gap);
    wa.delete(); wd.delete();
    model(q);
    pulse_start();
    send_bytes(q, gap);
    @(negedge clk);
    rx_valid = 0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    chk({tag, "_nwrites"}, 32'(wa.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wa.size(); i++) begin
      chk({tag, "_waddr"}, 32'(wa[i]), 32'(i));
      chk({tag, "_wdata"}, wd[i], exp_w[i]);
    end
  endtask

  typedef struct {
    logic [7:0]  hdr;
    logic [31:0] w0, w1;
    logic [7:0]  csum;
    logic        e_err;
    int          e_writes;
  } vec_t;

  vec_t vt[4];

  initial begin
    logic [7:0] q[$];

    vt[0] = '{8'h02, 32'h0000_0513, 32'h0010_0093, 8'h95, 1'b0, 2};
    vt[1] = '{8'h02, 32'h0000_0513, 32'h0010_0093, 8'h00, 1'b1, 2};
    vt[2] = '{8'h41, 32'h0, 32'h0, 8'h00, 1'b1, 0};
    vt[3] = '{8'h00, 32'h0, 32'h0, 8'h00, 1'b0, 0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 32'(rx_ready), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", wdata, 0);
    reset = 0;

    // Directed table.
    foreach (vt[v]) begin
      q.delete();
      q.push_back(vt[v].hdr);
      if (vt[v].hdr == 8'h02) begin
        for (int k = 0; k < 4; k++) q.push_back(vt[v].w0[8*k +: 8]);
        for (int k = 0; k < 4; k++) q.push_back(vt[v].w1[8*k +: 8]);
        q.push_back(vt[v].csum);
      end
      wa.delete(); wd.delete();
      pulse_start();
      chk("vec_busy_after_start", 32'(busy), 1);
      send_bytes(q, 0);
      @(negedge clk);
      rx_valid = 0;
      chk("vec_done", 32'(done), 1);
      chk("vec_err", 32'(err), 32'(vt[v].e_err));
      chk("vec_rx_ready_low", 32'(rx_ready), 0);
      chk("vec_nwrites", 32'(wa.size()), 32'(vt[v].e_writes));
      if (vt[v].e_writes == 2 && wa.size() == 2) begin
        chk("vec_addr0", 32'(wa[0]), 0);
        chk("vec_data0", wd[0], vt[v].w0);
        chk("vec_addr1", 32'(wa[1]), 1);
        chk("vec_data1", wd[1], vt[v].w1);
      end
    end

    // start while busy is ignored: a stray start mid-frame must not restart.
    q = '{8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
    wa.delete(); wd.delete();
    pulse_start();
    send_bytes('{8'h01, 8'hEF, 8'hBE}, 0);
    @(negedge clk); rx_valid = 0; start = 1;
    @(negedge clk); start = 0;
    send_bytes('{8'hAD, 8'hDE, 8'h22}, 0);
    @(negedge clk);
    chk("busy_start_done", 32'(done), 1);
    chk("busy_start_err", 32'(err), 0);
    chk("busy_start_nwrites", 32'(wa.size()), 1);
    if (wa.size() == 1) chk("busy_start_data", wd[0], 32'hDEAD_BEEF);

    // Reset after two data bytes aborts immediately.
    wa.delete(); wd.delete();
    pulse_start();
    send_bytes('{8'h02, 8'h13, 8'h05}, 0);
    @(negedge clk);
    rx_valid = 0;
    reset = 1;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_we", 32'(we), 0);
    chk("abort_rx_ready", 32'(rx_ready), 0);
    chk("abort_done", 32'(done), 0);
    @(negedge clk);
    reset = 0;
    chk("abort_nwrites", 32'(wa.size()), 0);
    q = '{8'h01, 8'h13, 8'h05, 8'h00, 8'h00, 8'h16};
    run_frame("after_abort", q, 0);

    // Full-depth load with random rx_valid gaps.
    q.delete();
    q.push_back(8'(DEPTH));
    for (int i = 0; i < 4 * DEPTH; i++) q.push_back(8'($urandom));
    begin
      logic [7:0] x = 0;
      for (int i = 1; i <= 4 * DEPTH; i++) x ^= q[i];
      q.push_back(x);
    end
    run_frame("full", q, 30);

    // Random frames: valid sizes with good/bad checksums, and oversize headers.
    for (int r = 0; r < 12; r++) begin
      int n;
      q.delete();
      if (r % 4 == 3) begin
        q.push_back(8'($urandom_range(255, DEPTH + 1)));
      end else begin
        logic [7:0] x = 0;
        n = $urandom_range(DEPTH, 1);
        q.push_back(8'(n));
        for (int i = 0; i < 4 * n; i++) begin
          q.push_back(8'($urandom));
          x ^= q[$];
        end
        q.push_back(($urandom_range(1) == 1) ? x : (x ^ 8'($urandom_range(255, 1))));
      end
      run_frame("rand", q, $urandom_range(50));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
